// File: rtl/sseg_pkg.sv
// sseg_pkg: shared write-select and FSM state encodings for the display-refresh controller
package sseg_pkg;
   localparam logic [1:0] SEL_HEX = 2'd0;
   localparam logic [1:0] SEL_PT  = 2'd1;
   localparam logic [1:0] SEL_LE  = 2'd2;
   localparam logic [1:0] SEL_BLK = 2'd3;
   typedef enum logic [1:0] {IDLE, LOAD, START, HOLD} state_e;
endpackage

// File: rtl/sseg_tick_div.sv
// sseg_tick_div: enable-gated modulo-DIV counter, tick high for the enabled cycle at count DIV-1
//   clk  in  system clock
//   rstn in  asynchronous active-low reset
//   en   in  advance the counter this cycle
//   tick out one-cycle pulse on wrap (combinational, qualified by en)
module sseg_tick_div #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic tick
);
   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/sseg_disp_ctrl.sv
// sseg_disp_ctrl: display-refresh controller feeding the serial seven-segment driver
//   clk, rstn        clock, asynchronous active-low reset
//   disp_en          refresh enable
//   wr_en/sel/data   shadow register write port (hex, points, blank, blink mask)
//   hexs/points/LEs  frozen display image presented to the driver
//   start            one-cycle frame request
//   busy             high while a frame is being loaded, started or held
module sseg_disp_ctrl
   import sseg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 250,
   parameter int unsigned HOLD_CYC    = 160
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        disp_en,
   input  logic        wr_en,
   input  logic [1:0]  wr_sel,
   input  logic [31:0] wr_data,
   output logic [31:0] hexs,
   output logic [7:0]  points,
   output logic [7:0]  LEs,
   output logic        start,
   output logic        busy
);
   localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   state_e         state_q, state_d;
   logic [31:0]    sh_hex_q, sh_hex_d, hexs_q, hexs_d;
   logic [7:0]     sh_pt_q, sh_pt_d, sh_le_q, sh_le_d, sh_blk_q, sh_blk_d;
   logic [7:0]     points_q, points_d, les_q, les_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           dirty_q, dirty_d, pend_q, pend_d, phase_q, phase_d;
   logic           tick, blink_tick;

   sseg_tick_div #(.DIV(REFRESH_DIV)) u_refresh (
      .clk(clk), .rstn(rstn), .en(1'b1), .tick(tick)
   );
   sseg_tick_div #(.DIV(BLINK_DIV)) u_blink (
      .clk(clk), .rstn(rstn), .en(tick), .tick(blink_tick)
   );

   always_comb begin
      sh_hex_d = (wr_en && wr_sel == SEL_HEX) ? wr_data : sh_hex_q;
      sh_pt_d  = (wr_en && wr_sel == SEL_PT)  ? wr_data[7:0] : sh_pt_q;
      sh_le_d  = (wr_en && wr_sel == SEL_LE)  ? wr_data[7:0] : sh_le_q;
      sh_blk_d = (wr_en && wr_sel == SEL_BLK) ? wr_data[7:0] : sh_blk_q;
      phase_d  = phase_q ^ blink_tick;
      // a write or blink toggle landing in LOAD must survive the clear
      dirty_d  = wr_en | blink_tick | (dirty_q & (state_q != LOAD));
      pend_d   = (tick & (state_q != IDLE)) | (pend_q & (state_q != LOAD));
      state_d  = state_q;
      hold_d   = hold_q;
      hexs_d   = hexs_q;
      points_d = points_q;
      les_d    = les_q;
      case (state_q)
         IDLE:  if (disp_en && (tick || pend_q || dirty_q)) state_d = LOAD;
         LOAD: begin
            hexs_d   = sh_hex_q;
            points_d = sh_pt_q;
            les_d    = sh_le_q | (phase_q ? sh_blk_q : 8'h00);
            state_d  = START;
         end
         START: begin
            // the start cycle itself is the first frozen cycle
            hold_d  = HW'(HOLD_CYC - 1);
            state_d = (HOLD_CYC > 1) ? HOLD : IDLE;
         end
         default: begin
            hold_d  = hold_q - 1'b1;
            state_d = (hold_q == HW'(1)) ? IDLE : HOLD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q  <= IDLE;
         sh_hex_q <= '0;
         sh_pt_q  <= '0;
         sh_le_q  <= '0;
         sh_blk_q <= '0;
         dirty_q  <= 1'b1;
         pend_q   <= 1'b0;
         phase_q  <= 1'b0;
         hold_q   <= '0;
         hexs_q   <= '0;
         points_q <= '0;
         les_q    <= 8'hFF;
      end else begin
         state_q  <= state_d;
         sh_hex_q <= sh_hex_d;
         sh_pt_q  <= sh_pt_d;
         sh_le_q  <= sh_le_d;
         sh_blk_q <= sh_blk_d;
         dirty_q  <= dirty_d;
         pend_q   <= pend_d;
         phase_q  <= phase_d;
         hold_q   <= hold_d;
         hexs_q   <= hexs_d;
         points_q <= points_d;
         les_q    <= les_d;
      end

   assign hexs   = hexs_q;
   assign points = points_q;
   assign LEs    = les_q;
   assign start  = (state_q == START);
   assign busy   = (state_q != IDLE);
endmodule
